// File: rtl/reg_40b_arb_pkg.sv
// Shared types and constants for the 40-bit register write arbiter.
package reg_40b_arb_pkg;

  localparam int unsigned REG_W  = 40;
  localparam int unsigned LCNT_W = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/reg_40b_arb_if.sv
// Requester-side bundle: requests, locks and words in; grant and register status out.
interface reg_40b_arb_if
  import reg_40b_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = REG_W
);

  localparam int unsigned IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   lock;
  logic [N_REQ*W-1:0] data;
  logic [N_REQ-1:0]   ack;
  logic [W-1:0]       out;
  logic [IDW-1:0]     owner;
  logic               locked;
  logic               upd;
  logic [IDW-1:0]     upd_id;

  modport master (
    output req, lock, data,
    input  ack, out, owner, locked, upd, upd_id
  );

  modport slave (
    input  req, lock, data,
    output ack, out, owner, locked, upd, upd_id
  );

endinterface

// File: rtl/reg_40b.sv
// Shared 40-bit storage word; reset takes priority over a coincident write.
module reg_40b
  import reg_40b_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [REG_W-1:0] in,
  output logic [REG_W-1:0] out
);

  logic [REG_W-1:0] val_q;
  logic [REG_W-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (wr_en) val_d = in;
  end

  always_ff @(posedge clk) begin
    if (rst) val_q <= '0;
    else     val_q <= val_d;
  end

  assign out = val_q;

endmodule

// File: rtl/reg_40b_arb_rr_pick.sv
// Circular priority picker: first set request at or after ptr, wrapping around.
module reg_40b_arb_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  int unsigned idx;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int off = int'(N) - 1; off >= 0; off--) begin
      idx = (32'(ptr) + 32'(off)) % N;
      if (req[IW'(idx)]) begin
        gnt_oh           = '0;
        gnt_oh[IW'(idx)] = 1'b1;
        gnt_idx          = IW'(idx);
        gnt_vld          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_40b_arb.sv
// Round-robin write arbiter with bounded lock bursts in front of one shared 40-bit register.
module reg_40b_arb
  import reg_40b_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic          clk,
  input  logic          rst,
  reg_40b_arb_if.slave  bus
);

  localparam int unsigned IDW = $clog2(N_REQ);

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      owner_q, owner_d;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
  logic                locked_q, locked_d;
  logic                upd_q, upd_d;
  logic [IDW-1:0]      upd_id_q, upd_id_d;

  logic [N_REQ-1:0]    pick_oh;
  logic [IDW-1:0]      pick_idx;
  logic                pick_vld;
  logic [N_REQ-1:0]    ack_c;
  logic [IDW-1:0]      wr_idx;
  logic                wr_en;
  logic [REG_W-1:0]    wr_data;
  logic [REG_W-1:0]    reg_out;

  reg_40b_arb_rr_pick #(
    .N  (N_REQ),
    .IW (IDW)
  ) u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      lcnt_q   <= '0;
      locked_q <= 1'b0;
      upd_q    <= 1'b0;
      upd_id_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      lcnt_q   <= lcnt_d;
      locked_q <= locked_d;
      upd_q    <= upd_d;
      upd_id_q <= upd_id_d;
    end
  end

  // Next state: pointer advances only on IDLE grants; lock bursts end on drop or limit.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    lcnt_d   = lcnt_q;
    upd_d    = wr_en;
    upd_id_d = wr_en ? wr_idx : upd_id_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          ptr_d = IDW'((32'(pick_idx) + 32'd1) % N_REQ);
          if (bus.lock[pick_idx]) begin
            state_d = ST_LOCKED;
            owner_d = pick_idx;
            lcnt_d  = LCNT_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        lcnt_d = lcnt_q + LCNT_W'(1);
        if (!bus.lock[owner_q] || (lcnt_q == LCNT_W'(MAX_LOCK))) begin
          state_d = ST_IDLE;
          lcnt_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    locked_d = (state_d == ST_LOCKED);
  end

  // Grant: round-robin pick in IDLE, owner only while locked.
  always_comb begin
    ack_c  = '0;
    wr_idx = pick_idx;
    case (state_q)
      ST_IDLE: ack_c = pick_oh;
      ST_LOCKED: begin
        wr_idx = owner_q;
        if (bus.req[owner_q]) ack_c[owner_q] = 1'b1;
      end
      default: ack_c = '0;
    endcase
    wr_en   = |ack_c;
    wr_data = bus.data[32'(wr_idx)*REG_W +: REG_W];
  end

  reg_40b u_reg (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .in    (wr_data),
    .out   (reg_out)
  );

  assign bus.ack    = ack_c;
  assign bus.out    = reg_out;
  assign bus.owner  = owner_q;
  assign bus.locked = locked_q;
  assign bus.upd    = upd_q;
  assign bus.upd_id = upd_id_q;

endmodule

// File: tb/tb_reg_40b_arb.sv
// Directed bench for reg_40b_arb: rotation, lock bursts, forced release, reset mid-burst, idle.
module tb_reg_40b_arb;
  import reg_40b_arb_pkg::*;

  localparam int unsigned N = 4;

  localparam logic [39:0] D0  = 40'h12_3456_789A;
  localparam logic [39:0] D1  = 40'hAA_0000_0001;
  localparam logic [39:0] D2  = 40'hBB_0000_0002;
  localparam logic [39:0] D2B = 40'hBB_0000_0022;
  localparam logic [39:0] D2C = 40'hBB_0000_0222;
  localparam logic [39:0] D3  = 40'hCC_0000_0003;
  localparam logic [39:0] DX  = 40'hDE_AD00_BEEF;
  localparam logic [39:0] DF  = 40'hFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_40b_arb_if #(.N_REQ(N), .W(REG_W)) bus();

  reg_40b_arb #(.N_REQ(N), .MAX_LOCK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [39:0] v);
    bus.data[i*40 +: 40] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle with a granted write: check ack now, then register outputs after the edge.
  task automatic wr(input string tag, input logic [3:0] r, input logic [3:0] l,
                    input logic [3:0] exp_ack, input int exp_id,
                    input logic [39:0] exp_out, input logic exp_locked);
    bus.req  = r;
    bus.lock = l;
    #1;
    check({tag, ".ack"}, 64'(bus.ack), 64'(exp_ack));
    tick();
    check({tag, ".out"}, 64'(bus.out), 64'(exp_out));
    check({tag, ".upd"}, 64'(bus.upd), 64'd1);
    check({tag, ".upd_id"}, 64'(bus.upd_id), 64'(exp_id));
    check({tag, ".locked"}, 64'(bus.locked), 64'(exp_locked));
  endtask

  // One cycle with no write expected.
  task automatic idle(input string tag, input logic [39:0] exp_out);
    bus.req  = '0;
    bus.lock = '0;
    #1;
    check({tag, ".ack"}, 64'(bus.ack), 64'd0);
    tick();
    check({tag, ".out"}, 64'(bus.out), 64'(exp_out));
    check({tag, ".upd"}, 64'(bus.upd), 64'd0);
  endtask

  initial begin
    rst      = 1'b1;
    bus.req  = '0;
    bus.lock = '0;
    bus.data = '0;
    set_data(0, D0);
    set_data(1, D1);
    set_data(2, D2);
    set_data(3, D3);
    repeat (2) @(posedge clk);
    #1;
    check("rst.out", 64'(bus.out), 64'd0);
    check("rst.ack", 64'(bus.ack), 64'd0);
    check("rst.locked", 64'(bus.locked), 64'd0);
    check("rst.upd", 64'(bus.upd), 64'd0);
    check("rst.upd_id", 64'(bus.upd_id), 64'd0);
    check("rst.owner", 64'(bus.owner), 64'd0);
    rst = 1'b0;

    // Single write, then wrap pointer back to 0.
    wr("single0", 4'b0001, 4'b0000, 4'b0001, 0, D0, 1'b0);
    wr("single3", 4'b1000, 4'b0000, 4'b1000, 3, D3, 1'b0);
    idle("gap", D3);

    // Full rotation from ptr=0.
    wr("rot0", 4'b1111, 4'b0000, 4'b0001, 0, D0, 1'b0);
    wr("rot1", 4'b1111, 4'b0000, 4'b0010, 1, D1, 1'b0);
    wr("rot2", 4'b1111, 4'b0000, 4'b0100, 2, D2, 1'b0);
    wr("rot3", 4'b1111, 4'b0000, 4'b1000, 3, D3, 1'b0);
    wr("rot4", 4'b1111, 4'b0000, 4'b0001, 0, D0, 1'b0);

    // Lock burst of 3 writes by requester 2, released by dropping lock.
    wr("pre1", 4'b1111, 4'b0000, 4'b0010, 1, D1, 1'b0);
    wr("lk2a", 4'b1111, 4'b0100, 4'b0100, 2, D2, 1'b1);
    check("lk2a.owner", 64'(bus.owner), 64'd2);
    set_data(2, D2B);
    wr("lk2b", 4'b1111, 4'b0100, 4'b0100, 2, D2B, 1'b1);
    set_data(2, D2C);
    wr("lk2c", 4'b1111, 4'b0000, 4'b0100, 2, D2C, 1'b0);
    wr("post3", 4'b1111, 4'b0000, 4'b1000, 3, D3, 1'b0);

    // Forced release of requester 1 after MAX_LOCK=4 locked cycles.
    wr("pre0", 4'b1111, 4'b0000, 4'b0001, 0, D0, 1'b0);
    wr("fr_g", 4'b1111, 4'b0010, 4'b0010, 1, D1, 1'b1);
    check("fr_g.owner", 64'(bus.owner), 64'd1);
    wr("fr_1", 4'b1111, 4'b0010, 4'b0010, 1, D1, 1'b1);
    wr("fr_2", 4'b1111, 4'b0010, 4'b0010, 1, D1, 1'b1);
    wr("fr_3", 4'b1111, 4'b0010, 4'b0010, 1, D1, 1'b1);
    wr("fr_4", 4'b1111, 4'b0010, 4'b0010, 1, D1, 1'b0);
    wr("fr_next", 4'b1111, 4'b0010, 4'b0100, 2, D2C, 1'b0);

    // Reset while locked with a pending write: write discarded.
    wr("rl_g", 4'b1111, 4'b1000, 4'b1000, 3, D3, 1'b1);
    set_data(3, DX);
    rst      = 1'b1;
    bus.req  = 4'b1000;
    bus.lock = 4'b1000;
    #1;
    check("rl.ack", 64'(bus.ack), 64'b1000);
    tick();
    check("rl.out", 64'(bus.out), 64'd0);
    check("rl.locked", 64'(bus.locked), 64'd0);
    check("rl.upd", 64'(bus.upd), 64'd0);
    rst = 1'b0;

    // All-ones write, long idle, pointer retained.
    set_data(0, DF);
    wr("ff", 4'b0001, 4'b0000, 4'b0001, 0, DF, 1'b0);
    for (int i = 0; i < 10; i++) idle($sformatf("idle%0d", i), DF);
    wr("ptr_kept", 4'b1111, 4'b0000, 4'b0010, 1, D1, 1'b0);
    wr("wrap", 4'b0001, 4'b0000, 4'b0001, 0, DF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_40b_arb.md
# reg_40b_arb

Round-robin write arbiter that shares one 40-bit storage register among N_REQ requesters. Each requester presents a 40-bit word with a request; the arbiter grants at most one write per cycle, acknowledges the winner, and drives the register's write enable and data. A requester may lock the register for a burst of consecutive writes, bounded by a starvation limit. The block sits between producer units and a single shared 40-bit configuration/status word.

## Interface
- N_REQ, 4: number of requesters (2..8).
- W, 40: data width; fixed at 40 for the reg_40b storage instance.
- MAX_LOCK, 16: maximum cycles a lock may be held (1..255).

- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- req  in  N_REQ  per-requester write request; held until acked.
- lock  in  N_REQ  per-requester lock request; sampled only with a granted write or while that requester is owner.
- data  in  N_REQ*W  requester i's word at bits [i*W +: W].
- ack  out  N_REQ  one-hot grant; combinational, same cycle as the write.
- out  out  W  stored register value.
- owner  out  clog2(N_REQ)  current lock owner; valid only while locked.
- locked  out  1  high in LOCKED state.
- upd  out  1  registered pulse, one cycle after each write.
- upd_id  out  clog2(N_REQ)  index of the requester whose write caused upd.

## Operation
- State: FSM {IDLE, LOCKED}, rr pointer ptr, owner register, lock cycle counter lcnt (8 bits), upd/upd_id registers.
- Reset values: state=IDLE, ptr=0, owner=0, lcnt=0, out=0, ack=0, locked=0, upd=0, upd_id=0.
- IDLE:
  - If any req is set, grant g = first index with req set, searching circularly from ptr.
  - ack[g]=1, wr_en=1, in=data[g]. Set ptr <= (g+1) mod N_REQ.
  - If lock[g]=1 in the same cycle, go to LOCKED with owner<=g and lcnt<=1.
  - With no req set, nothing is written and ptr holds.
- LOCKED:
  - Only owner is eligible. If req[owner]=1, ack and write. Other requests wait with ack=0.
  - lcnt increments every LOCKED cycle, whether or not a write occurs. ptr does not change.
  - Exit to IDLE at the end of a cycle when any of these holds:
    - lock[owner]=0. A write in that same cycle is still granted and is the last one.
    - lcnt==MAX_LOCK (forced release).
  - On exit, lcnt<=0. Because ptr=owner+1, the owner has lowest priority in the next IDLE cycle.
- ack is never asserted to a requester whose req is 0. At most one ack bit is high.
- The lock input of a requester that is not granted or not owner is ignored.
- Simultaneous events:
  - Forced release and lock[owner]=1 in the same cycle: release wins.
  - A write in the release cycle is still performed.

## Timing
- Grant latency: 0 cycles. ack is combinational from req and registered state.
- Write visibility: out takes the new value on the clock edge ending the ack cycle, i.e. 1 cycle later.
- upd/upd_id: asserted in the cycle after ack, for exactly 1 cycle.
- Throughput: 1 write per cycle sustained, including back-to-back grants to different requesters.
- Handshake: the requester holds req and data stable until it sees ack. It may drop req or change data in the cycle after ack.
- Reset mid-burst: at the reset edge, state→IDLE and out→0. A write coincident with rst is discarded (rst has priority over wr_en). ack is 0 in the first cycle after reset only if req is 0.

## Structure
- Shared package: FSM state enum (ST_IDLE, ST_LOCKED), the data width constant REG_W=40, and the lcnt width constant.
- Sub-module rr_pick: combinational circular priority picker (req vector, ptr → one-hot grant plus index). It is reusable by other arbiters.
- Storage: one instance of the team's reg_40b, with wr_en=|ack, in=muxed data, and clk/rst passed through.
- The FSM, counter and upd registers are kept in the top module.

## Test plan
- Reset, then req=4'b0001 with data0=40'h12_3456_789A → ack=0001 in the same cycle. The next cycle has out=40'h12_3456_789A, upd=1, upd_id=0.
- With ptr=0, hold req=4'b1111 continuously → acks rotate 0,1,2,3,0 on consecutive cycles, each value appearing on out 1 cycle later.
- Requester 2 granted with lock=1, lock held for 3 writes while req=1111 → ack=0100 for 3 cycles. It drops lock on the 3rd write, then the next grant is to requester 3.
- MAX_LOCK=4, requester 1 holds req and lock continuously → locked for exactly 4 cycles, forced release, and the next grant goes to requester 2 with requester 1 waiting.
- Assert rst during LOCKED with a pending write → out=0, locked=0, upd=0 next cycle, and the coincident write is not stored.
- req=0 for 10 cycles after writing 40'hFF_FFFF_FFFF → out stable, no ack, no upd, ptr unchanged.
